// File: rtl/delay_sweep_ctrl.sv
// Delay-calibration sequencer: steps selected delay fields of selected colour
// channels across a range, running a settle / send / dwell / stop cycle per setting.
module delay_sweep_ctrl #(
  parameter int unsigned DELAY_W    = 4,
  parameter int unsigned MAX_DELAY  = 10,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned DWELL_CYC  = 1024,
  parameter int unsigned PULSE_CYC  = 10,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk_x10,
  input  logic                   g_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             sweep_sel,
  input  logic [2:0]             ch_mask,
  input  logic [DELAY_W-1:0]     start_val,
  input  logic [DELAY_W-1:0]     stop_val,
  input  logic [DELAY_W-1:0]     step,
  output logic [3*DELAY_W-1:0]   whole_delay,
  output logic [3*DELAY_W-1:0]   rising_delay,
  output logic [3*DELAY_W-1:0]   falling_delay,
  output logic                   send_enable,
  output logic                   send_stop,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   aborted,
  output logic [3:0]             step_idx,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SEND   = 3'd3,
    DWELL  = 3'd4,
    STOP   = 3'd5,
    NEXT   = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam logic [DELAY_W-1:0] MAX_V       = DELAY_W'(MAX_DELAY);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(PULSE_CYC - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     timer, timer_nxt;
  logic [1:0]           sel_q;
  logic [2:0]           mask_q;
  logic [DELAY_W-1:0]   stop_q, step_q, cur;
  logic [DELAY_W:0]     sum_c;
  logic                 cfg_bad_c, req_c, last_c;
  logic [3*DELAY_W-1:0] whole_c, rising_c, falling_c;

  assign sum_c     = {1'b0, cur} + {1'b0, step_q};
  assign last_c    = sum_c > {1'b0, stop_q};
  assign cfg_bad_c = (start_val > stop_val) || (stop_val > MAX_V) || (ch_mask == 3'b000);
  assign req_c     = (state == IDLE) && start && !abort;
  assign state_dbg = state;

  // Next state and phase timer
  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    case (state)
      IDLE:   if (req_c && !cfg_bad_c) state_nxt = LOAD;
      LOAD:   state_nxt = abort ? DONE : SETTLE;
      SETTLE: begin
        if (abort)                    state_nxt = DONE;
        else if (timer == SETTLE_LAST) state_nxt = SEND;
        else                          timer_nxt = timer + CNT_W'(1);
      end
      SEND: begin
        if (abort)                   state_nxt = STOP;
        else if (timer == PULSE_LAST) state_nxt = DWELL;
        else                         timer_nxt = timer + CNT_W'(1);
      end
      DWELL: begin
        if (abort)                   state_nxt = STOP;
        else if (timer == DWELL_LAST) state_nxt = STOP;
        else                         timer_nxt = timer + CNT_W'(1);
      end
      STOP: begin
        // an abort seen earlier or now still lets the stop pulse run to length
        if (timer == PULSE_LAST) state_nxt = (aborted || abort) ? DONE : NEXT;
        else                     timer_nxt = timer + CNT_W'(1);
      end
      NEXT:   state_nxt = (abort || last_c) ? DONE : LOAD;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Field values presented when a setting is loaded
  always_comb begin
    whole_c   = '0;
    rising_c  = '0;
    falling_c = '0;
    for (int c = 0; c < 3; c++) begin
      if (mask_q[c]) begin
        if (sel_q == 2'd0)                    whole_c[c*DELAY_W +: DELAY_W]   = cur;
        if (sel_q == 2'd1 || sel_q == 2'd3)   rising_c[c*DELAY_W +: DELAY_W]  = cur;
        if (sel_q == 2'd2 || sel_q == 2'd3)   falling_c[c*DELAY_W +: DELAY_W] = cur;
      end
    end
  end

  always_ff @(posedge clk_x10) begin
    if (!g_rst) begin
      state         <= IDLE;
      timer         <= '0;
      sel_q         <= '0;
      mask_q        <= '0;
      stop_q        <= '0;
      step_q        <= '0;
      cur           <= '0;
      whole_delay   <= '0;
      rising_delay  <= '0;
      falling_delay <= '0;
      send_enable   <= 1'b0;
      send_stop     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      aborted       <= 1'b0;
      step_idx      <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      send_enable <= (state_nxt == SEND);
      send_stop   <= (state_nxt == STOP);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);

      if (req_c) begin
        sel_q  <= sweep_sel;
        mask_q <= ch_mask;
        stop_q <= stop_val;
        step_q <= (step == '0) ? DELAY_W'(1) : step;
        if (cfg_bad_c) begin
          err <= 1'b1;
        end else begin
          err      <= 1'b0;
          aborted  <= 1'b0;
          cur      <= start_val;
          step_idx <= '0;
        end
      end

      if (state != IDLE && abort) aborted <= 1'b1;

      if (state == LOAD) begin
        whole_delay   <= whole_c;
        rising_delay  <= rising_c;
        falling_delay <= falling_c;
      end

      if (state == NEXT && !abort && !last_c) begin
        cur <= sum_c[DELAY_W-1:0];
        if (step_idx != 4'hF) step_idx <= step_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Randomized self-checking bench for delay_sweep_ctrl against a setting-list model.
`timescale 1ns/1ps
module tb_delay_sweep_ctrl;

  localparam int SET_CYC = 1 + 16 + 10 + 1024 + 10 + 1;

  logic        clk_x10 = 1'b0;
  logic        g_rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0]  sweep_sel = '0;
  logic [2:0]  ch_mask = '0;
  logic [3:0]  start_val = '0, stop_val = '0, step = '0;
  logic [11:0] whole_delay, rising_delay, falling_delay;
  logic        send_enable, send_stop, busy, done, err, aborted;
  logic [3:0]  step_idx;
  logic [2:0]  state_dbg;

  int checks = 0, passed = 0;

  delay_sweep_ctrl dut (
    .clk_x10(clk_x10), .g_rst(g_rst), .start(start), .abort(abort),
    .sweep_sel(sweep_sel), .ch_mask(ch_mask), .start_val(start_val),
    .stop_val(stop_val), .step(step), .whole_delay(whole_delay),
    .rising_delay(rising_delay), .falling_delay(falling_delay),
    .send_enable(send_enable), .send_stop(send_stop), .busy(busy),
    .done(done), .err(err), .aborted(aborted), .step_idx(step_idx),
    .state_dbg(state_dbg)
  );

  always #5 clk_x10 = ~clk_x10;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pulse / snapshot monitor, sampled on the falling edge
  logic [35:0] snap_q[$];
  int          en_len_q[$], stp_len_q[$];
  int          en_run, stp_run, done_cnt, overlap_cnt;
  logic        en_prev = 1'b0, stp_prev = 1'b0;

  always @(negedge clk_x10) begin
    if (send_enable) begin
      if (!en_prev) snap_q.push_back({whole_delay, rising_delay, falling_delay});
      en_run++;
    end else if (en_prev) begin
      en_len_q.push_back(en_run);
      en_run = 0;
    end
    en_prev = send_enable;
    if (send_stop) stp_run++;
    else if (stp_prev) begin
      stp_len_q.push_back(stp_run);
      stp_run = 0;
    end
    stp_prev = send_stop;
    if (send_enable && send_stop) overlap_cnt++;
    if (done) done_cnt++;
  end

  // Reference: the list of {whole,rising,falling} settings a sweep must visit
  logic [35:0] exp_q[$];
  function automatic int model(input logic [1:0] sel, input logic [2:0] mask,
                               input int sv, input int ev, input int st);
    int s;
    logic [11:0] ch;
    logic [35:0] e;
    s = (st == 0) ? 1 : st;
    exp_q.delete();
    for (int v = sv; v <= ev; v += s) begin
      ch = {mask[2] ? 4'(v) : 4'd0, mask[1] ? 4'(v) : 4'd0, mask[0] ? 4'(v) : 4'd0};
      e = '0;
      if (sel == 2'd0) e[35:24] = ch;
      if (sel == 2'd1 || sel == 2'd3) e[23:12] = ch;
      if (sel == 2'd2 || sel == 2'd3) e[11:0] = ch;
      exp_q.push_back(e);
    end
    return exp_q.size();
  endfunction

  int          t_done, idx_done;
  logic        abt_done, busy_after;
  logic [35:0] first_snap, hold_snap;
  logic [48:0] post_rst;

  // Drives one sweep; t counts cycles after the start-sampling edge (LOAD is t=1)
  task automatic run_sweep(input logic [1:0] sel, input logic [2:0] mask, input int sv,
                           input int ev, input int st, input int abort_t, input int rst_t,
                           input int limit);
    int t;
    snap_q.delete(); en_len_q.delete(); stp_len_q.delete();
    done_cnt = 0; overlap_cnt = 0; en_run = 0; stp_run = 0;
    t_done = -1; idx_done = -1; abt_done = 1'b0;
    @(posedge clk_x10); #1;
    sweep_sel = sel; ch_mask = mask; start_val = 4'(sv); stop_val = 4'(ev); step = 4'(st);
    start = 1'b1;
    @(posedge clk_x10); #1;
    start = 1'b0;
    t = 1;
    while (t <= limit) begin
      if (t == 2) first_snap = {whole_delay, rising_delay, falling_delay};
      if (done) begin
        t_done = t; idx_done = step_idx; abt_done = aborted;
        break;
      end
      if (t == rst_t + 1) begin
        post_rst = {whole_delay, rising_delay, falling_delay, send_enable, send_stop,
                    busy, done, err, aborted, step_idx, state_dbg};
        g_rst = 1'b1;
        break;
      end
      if (t == rst_t) g_rst = 1'b0;
      if (t == 3) begin
        sweep_sel = 2'($urandom); ch_mask = 3'($urandom);
        start_val = 4'($urandom); stop_val = 4'($urandom); step = 4'($urandom);
      end
      start = (t == 50);
      abort = (t == abort_t);
      @(posedge clk_x10); #1;
      t++;
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk_x10); #1;
    busy_after = busy;
    hold_snap  = {whole_delay, rising_delay, falling_delay};
  endtask

  task automatic test_reset();
    logic [48:0] v;
    ch_mask = 3'b111; start_val = 4'd1; stop_val = 4'd5;
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      @(posedge clk_x10); #1;
      v = {whole_delay, rising_delay, falling_delay, send_enable, send_stop,
           busy, done, err, aborted, step_idx, state_dbg};
      checks++;
      if (v !== 49'd0) $display("FAIL reset_outputs cycle %0d got %h want 0", i, v);
      else passed++;
    end
    start = 1'b0;
    g_rst = 1'b1;
  endtask

  task automatic test_sweeps();
    logic [1:0] sel;
    logic [2:0] mask;
    int sv, ev, st, n, hi, want;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin sel = 2'd0; mask = 3'b101; sv = 2;  ev = 6;  st = 2; end
        1: begin sel = 2'd3; mask = 3'b010; sv = 10; ev = 10; st = 0; end
        2: begin sel = 2'd1; mask = 3'b111; sv = 9;  ev = 10; st = 4; end
        default: begin
          sel  = 2'($urandom_range(3, 0));
          mask = 3'($urandom_range(7, 1));
          sv   = $urandom_range(10, 0);
          hi   = (sv + 3 > 10) ? 10 : sv + 3;
          ev   = $urandom_range(hi, sv);
          st   = $urandom_range(4, 0);
        end
      endcase
      n = model(sel, mask, sv, ev, st);
      run_sweep(sel, mask, sv, ev, st, -1, -10, n * SET_CYC + 20);
      checks++;
      if (t_done !== n * SET_CYC + 1) $display("FAIL sweep%0d done_time got %0d want %0d", i, t_done, n * SET_CYC + 1);
      else passed++;
      checks++;
      if (done_cnt !== 1) $display("FAIL sweep%0d done_pulses got %0d want 1", i, done_cnt);
      else passed++;
      checks++;
      if (first_snap !== exp_q[0]) $display("FAIL sweep%0d first_value got %h want %h", i, first_snap, exp_q[0]);
      else passed++;
      checks++;
      if (snap_q.size() !== n) $display("FAIL sweep%0d settings got %0d want %0d", i, snap_q.size(), n);
      else passed++;
      for (int j = 0; j < n && j < snap_q.size(); j++) begin
        checks++;
        if (snap_q[j] !== exp_q[j]) $display("FAIL sweep%0d setting%0d got %h want %h", i, j, snap_q[j], exp_q[j]);
        else passed++;
      end
      checks++;
      if (en_len_q.size() !== n || stp_len_q.size() !== n)
        $display("FAIL sweep%0d pulse_count got en=%0d stop=%0d want %0d", i, en_len_q.size(), stp_len_q.size(), n);
      else passed++;
      for (int j = 0; j < en_len_q.size(); j++) begin
        checks++;
        if (en_len_q[j] !== 10) $display("FAIL sweep%0d en_len%0d got %0d want 10", i, j, en_len_q[j]);
        else passed++;
      end
      for (int j = 0; j < stp_len_q.size(); j++) begin
        checks++;
        if (stp_len_q[j] !== 10) $display("FAIL sweep%0d stop_len%0d got %0d want 10", i, j, stp_len_q[j]);
        else passed++;
      end
      checks++;
      if (overlap_cnt !== 0) $display("FAIL sweep%0d overlap got %0d want 0", i, overlap_cnt);
      else passed++;
      want = (n - 1 > 15) ? 15 : n - 1;
      checks++;
      if (idx_done !== want || abt_done !== 1'b0)
        $display("FAIL sweep%0d idx_aborted got %0d/%b want %0d/0", i, idx_done, abt_done, want);
      else passed++;
      checks++;
      if (busy_after !== 1'b0 || hold_snap !== exp_q[n-1])
        $display("FAIL sweep%0d end_hold got busy=%b %h want busy=0 %h", i, busy_after, hold_snap, exp_q[n-1]);
      else passed++;
    end
  endtask

  task automatic test_config_err();
    int sv, ev;
    logic [2:0] mask;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sv = 7; ev = 3;  mask = 3'b111; end
        1: begin sv = 2; ev = 11; mask = 3'b111; end
        default: begin sv = 2; ev = 5; mask = 3'b000; end
      endcase
      done_cnt = 0;
      @(posedge clk_x10); #1;
      start_val = 4'(sv); stop_val = 4'(ev); ch_mask = mask; step = 4'd1; start = 1'b1;
      @(posedge clk_x10); #1;
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || state_dbg !== 3'd0)
        $display("FAIL cfg_err%0d got err=%b busy=%b st=%0d want 1/0/0", i, err, busy, state_dbg);
      else passed++;
      repeat (3) @(posedge clk_x10);
      #1;
      checks++;
      if (done_cnt !== 0 || busy !== 1'b0) $display("FAIL cfg_err%0d_nodone got done=%0d busy=%b want 0/0", i, done_cnt, busy);
      else passed++;
    end
    run_sweep(2'd0, 3'b111, 3, 5, 1, 3, -10, 100);
    checks++;
    if (err !== 1'b0 || t_done !== 4) $display("FAIL cfg_err_clear got err=%b done_t=%0d want 0/4", err, t_done);
    else passed++;
  endtask

  task automatic test_abort();
    int at, want_done, want_en, want_en_len, want_stp, n_snap;
    void'(model(2'd0, 3'b111, 1, 5, 1));
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin at = 128; want_done = 139; want_en = 1; want_en_len = 10; want_stp = 1; end
        1: begin at = 5;   want_done = 6;   want_en = 0; want_en_len = 0;  want_stp = 0; end
        default: begin at = 20; want_done = 31; want_en = 1; want_en_len = 3; want_stp = 1; end
      endcase
      run_sweep(2'd0, 3'b111, 1, 5, 1, at, -10, 1500);
      checks++;
      if (t_done !== want_done || abt_done !== 1'b1)
        $display("FAIL abort%0d done got t=%0d ab=%b want t=%0d ab=1", i, t_done, abt_done, want_done);
      else passed++;
      checks++;
      if (en_len_q.size() !== want_en || stp_len_q.size() !== want_stp)
        $display("FAIL abort%0d pulses got en=%0d stop=%0d want %0d/%0d", i, en_len_q.size(), stp_len_q.size(), want_en, want_stp);
      else passed++;
      for (int j = 0; j < en_len_q.size(); j++) begin
        checks++;
        if (en_len_q[j] !== want_en_len) $display("FAIL abort%0d en_len got %0d want %0d", i, en_len_q[j], want_en_len);
        else passed++;
      end
      for (int j = 0; j < stp_len_q.size(); j++) begin
        checks++;
        if (stp_len_q[j] !== 10) $display("FAIL abort%0d stop_len got %0d want 10", i, stp_len_q[j]);
        else passed++;
      end
      n_snap = snap_q.size();
      repeat (30) @(posedge clk_x10);
      #1;
      checks++;
      if (snap_q.size() !== n_snap || state_dbg !== 3'd0 || busy !== 1'b0 || done_cnt !== 1)
        $display("FAIL abort%0d quiet got snaps=%0d st=%0d busy=%b done=%0d want %0d/0/0/1",
                 i, snap_q.size(), state_dbg, busy, done_cnt, n_snap);
      else passed++;
      if (i == 0) begin
        checks++;
        if (snap_q.size() !== 1 || snap_q[0] !== exp_q[0]) $display("FAIL abort0 setting got n=%0d want 1 at %h", snap_q.size(), exp_q[0]);
        else passed++;
      end
    end
    run_sweep(2'd1, 3'b100, 4, 4, 0, -1, -10, SET_CYC + 20);
    checks++;
    if (abt_done !== 1'b0 || aborted !== 1'b0 || t_done !== SET_CYC + 1)
      $display("FAIL abort_clear got ab=%b/%b t=%0d want 0/0/%0d", abt_done, aborted, t_done, SET_CYC + 1);
    else passed++;
    @(posedge clk_x10); #1;
    ch_mask = 3'b111; start_val = 4'd1; stop_val = 4'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk_x10); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk_x10); #1;
    checks++;
    if (busy !== 1'b0 || state_dbg !== 3'd0 || aborted !== 1'b0)
      $display("FAIL abort_idle got busy=%b st=%0d ab=%b want 0/0/0", busy, state_dbg, aborted);
    else passed++;
  endtask

  task automatic test_reset_mid();
    run_sweep(2'd0, 3'b111, 2, 4, 1, -1, 500, 600);
    checks++;
    if (post_rst !== 49'd0) $display("FAIL reset_mid got %h want 0", post_rst);
    else passed++;
    checks++;
    if (t_done !== -1 || done_cnt !== 0 || state_dbg !== 3'd0 || busy !== 1'b0 || whole_delay !== 12'd0)
      $display("FAIL reset_mid_after got t=%0d done=%0d st=%0d busy=%b whole=%h want -1/0/0/0/0",
               t_done, done_cnt, state_dbg, busy, whole_delay);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sweeps();
    test_config_err();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/delay_sweep_ctrl.md
Name: delay_sweep_ctrl

Overview:
- Automatic delay-calibration sequencer for the PAM4 RGB transmit path. Runs in the clk_x10 domain and replaces manual button stepping.
- Steps a selected delay field (whole, rising, falling, or rising+falling) of selected colour channels from start_val to stop_val.
- At each setting it waits for the delay pipeline to settle, then starts PRBS transmission, dwells, and stops transmission.
- Its outputs feed the eq_delay and init_delay value inputs and the data_gen send_enable/send_stop inputs, muxed against manual control.

Parameters:
DELAY_W, 4, width of each per-channel delay value
MAX_DELAY, 10, largest legal delay value
SETTLE_CYC, 16, clk_x10 cycles waited after loading a new value
DWELL_CYC, 1024, clk_x10 cycles of transmission per setting
PULSE_CYC, 10, stretch length of send_enable/send_stop (one clk_x1 period at divide-by-10)
CNT_W, 16, width of the internal timer; must hold max(SETTLE_CYC, DWELL_CYC, PULSE_CYC)

Ports:
clk_x10  in  1  fast system clock
g_rst  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse requesting a sweep
abort  in  1  single-cycle pulse requesting early termination
sweep_sel  in  2  0=whole, 1=rising, 2=falling, 3=rising and falling together
ch_mask  in  3  channel enable, [2]=r [1]=g [0]=b
start_val  in  DELAY_W  first delay value
stop_val  in  DELAY_W  last delay value (inclusive)
step  in  DELAY_W  increment; 0 is treated as 1
whole_delay  out  3*DELAY_W  {r,g,b} whole-delay values
rising_delay  out  3*DELAY_W  {r,g,b} rising-edge delay values
falling_delay  out  3*DELAY_W  {r,g,b} falling-edge delay values
send_enable  out  1  transmit-start pulse, PULSE_CYC cycles high
send_stop  out  1  transmit-stop pulse, PULSE_CYC cycles high
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse at sweep end
err  out  1  config error flag
aborted  out  1  last sweep ended by abort
step_idx  out  4  index of the current setting, 0-based
state_dbg  out  3  encoded FSM state for LEDs

Behaviour:
- Reset (g_rst low at a clock edge), from any state: state=IDLE; all delay outputs 0; send_enable, send_stop, busy, done, err and aborted all 0; step_idx 0; timer 0.
- Encoding: IDLE=0, LOAD=1, SETTLE=2, SEND=3, DWELL=4, STOP=5, NEXT=6, DONE=7.
- IDLE, start with abort low:
  - Latch sweep_sel, ch_mask, start_val, stop_val and step (0 replaced by 1).
  - If start_val>stop_val, stop_val>MAX_DELAY, or ch_mask==0: set err=1 and stay in IDLE; busy stays 0 and no done pulse.
  - Otherwise clear err and aborted, set cur=start_val, step_idx=0, busy=1, and go to LOAD.
- start while busy: ignored. Latched config never changes mid-sweep.
- LOAD (1 cycle):
  - In each masked channel, the selected field(s) are driven to cur.
  - All non-selected fields and unmasked channels are driven to 0.
  - Values are visible on the outputs in the cycle after LOAD (start accepted at cycle N gives the new values at N+2).
- SETTLE: timer counts SETTLE_CYC cycles, then go to SEND.
- SEND: send_enable high for exactly PULSE_CYC consecutive cycles, then DWELL.
- DWELL: DWELL_CYC cycles, then STOP.
- STOP: send_stop high for exactly PULSE_CYC cycles, then NEXT.
- NEXT (1 cycle):
  - Compute cur+step at DELAY_W+1 bits (no wrap).
  - If the result > stop_val, go to DONE.
  - Otherwise cur += step, step_idx += 1 (saturating at 15), and go to LOAD.
- DONE (1 cycle): done=1, busy drops to 0 in the following cycle, return to IDLE. Delay outputs hold their last values until the next accepted start or reset.
- abort while busy (takes effect on the next edge):
  - In SEND or DWELL: go to STOP and emit a full send_stop pulse; a partially emitted send_enable is truncated.
  - In LOAD, SETTLE or NEXT: go straight to DONE.
  - In STOP: finish the pulse, then DONE.
  - Always set aborted=1.
- abort in IDLE: no effect. abort and start in the same cycle in IDLE: abort wins and start is ignored.
- send_enable and send_stop are never high in the same cycle.
- Every output is registered; there are no combinational input-to-output paths.

Test Plan:
1. Reset: hold g_rst=0 for 5 cycles with start toggling -> all outputs 0, state_dbg=0, no pulses.
2. Whole sweep: sweep_sel=0, ch_mask=3'b101, start=2, stop=6, step=2.
   - whole_delay r/b steps 2, 4, 6 with g=0; rising and falling stay 0.
   - 3 send_enable and 3 send_stop pulses, each 10 cycles long.
   - step_idx ends at 2 and done pulses once.
   - First value appears 2 cycles after start.
3. sweep_sel=3, ch_mask=3'b010, start=stop=10, step=0 -> exactly one setting; rising_g=falling_g=10; step=0 behaves as 1.
4. Config errors: start=7, stop=3 -> err=1, busy=0, no done. Then stop=11 (>MAX_DELAY) -> err=1. Then a valid start -> err clears.
5. Abort at DWELL cycle 100 -> send_stop pulse of 10 cycles, done, aborted=1, no further LOAD. Abort during SETTLE -> done next cycle with no send_stop.
6. Boundary: start=9, stop=10, step=4 -> single setting at 9, with no wrap to 13. Assert g_rst mid-DWELL -> immediate return to IDLE with all outputs 0.
